// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: drives the byte-serial AES-128 key expander through its
// 7-cycle-per-round step sequence, captures every expanded round key and
// hands round keys 0..10 to the cipher datapath through a small FIFO with a
// valid/ready handshake. One schedule runs per reset.
module aes_key_sched_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic [3:0]   ke_round_o,
    output logic [2:0]   ke_cnt_o,
    input  logic [127:0] ke_round_key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_data_o,
    output logic [3:0]   rk_idx_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = FIFO_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        CAP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         round_q, round_d;
    logic [2:0]         cnt_q, cnt_d;

    logic [127:0]       mem_data_q [FIFO_DEPTH];
    logic [127:0]       mem_data_d [FIFO_DEPTH];
    logic [3:0]         mem_idx_q  [FIFO_DEPTH];
    logic [3:0]         mem_idx_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fifo_full;
    logic               pop;
    logic               can_push;
    logic               push;
    logic [127:0]       push_data;
    logic [3:0]         push_idx;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = rk_valid_o && rk_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_push  = !fifo_full || pop;

    // Sequencer next-state: step the expander, decide when a round key is pushed.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = key_i;
        push_idx  = 4'd0;
        case (state_q)
            IDLE: begin
                cnt_d = 3'd7;
                if (start_i && can_push) begin
                    push    = 1'b1;
                    round_d = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (cnt_q == 3'd5) begin
                    cnt_d   = 3'd6;
                    state_d = CAP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CAP: begin
                cnt_d = 3'd6;
                if (can_push) begin
                    push      = 1'b1;
                    push_data = ke_round_key_i;
                    push_idx  = round_q + 4'd1;
                    if (round_q == 4'(NUM_ROUNDS - 1)) begin
                        cnt_d   = 3'd7;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        cnt_d   = 3'd0;
                        state_d = GEN;
                    end
                end
            end
            DONE: begin
                cnt_d = 3'd7;
            end
            default: begin
                cnt_d   = 3'd7;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO next-state: write at the tail on push, advance the head on pop.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_idx_d  = mem_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_idx_d[wr_ptr_q]  = push_idx;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // All sequencer and FIFO state registers, cleared by the shared reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            cnt_q    <= 3'd7;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_idx_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_data_q <= mem_data_d;
            mem_idx_q  <= mem_idx_d;
        end
    end

    assign ke_round_o = round_q;
    assign ke_cnt_o   = cnt_q;
    assign rk_valid_o = (count_q != '0);
    assign rk_data_o  = mem_data_q[rd_ptr_q];
    assign rk_idx_o   = mem_idx_q[rd_ptr_q];
    assign busy_o     = (state_q == GEN) || (state_q == CAP);
    assign done_o     = (state_q == DONE) && (count_q == '0);

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: stands in for the key expander with a
// word-level AES-128 model, scoreboards the delivered round keys against a
// software key schedule and checks the step-counter protocol every cycle.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic [3:0]   ke_round_o;
    logic [2:0]   ke_cnt_o;
    logic [127:0] ke_round_key_i;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic [127:0] rk_data_o;
    logic [3:0]   rk_idx_o;
    logic         busy_o;
    logic         done_o;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int           vectors     = 0;
    int           miscompares = 0;
    int           ncyc        = 0;
    int           exp_idx     = 0;
    int           cnt5_count  = 0;
    int           cur_stall   = 0;
    int           max_stall   = 0;
    int           ready_mode  = 0;
    int           ready_release = 0;
    int           t0          = 0;
    int           first_seen [11];
    logic [127:0] sched [11];
    logic [127:0] exp_key;
    logic         prev_valid;
    logic         prev_ready;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    logic [2:0]   prev_cnt;

    aes_key_sched_ctrl #(.FIFO_DEPTH(2), .NUM_ROUNDS(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .key_i          (key_i),
        .ke_round_o     (ke_round_o),
        .ke_cnt_o       (ke_cnt_o),
        .ke_round_key_i (ke_round_key_i),
        .rk_valid_o     (rk_valid_o),
        .rk_ready_i     (rk_ready_i),
        .rk_data_o      (rk_data_o),
        .rk_idx_o       (rk_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        logic [7:0] e   = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < int'(i); k++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic computeSchedule(input logic [127:0] key);
        sched[0] = key;
        for (int r = 1; r <= 10; r++) sched[r] = nextKey(sched[r-1], rcon(4'(r - 1)));
    endtask

    // Expander stand-in: reloads the key on reset, advances one round when the
    // step sequence completes, and holds otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_key <= key_i;
        else if (ke_cnt_o == 3'd5) exp_key <= nextKey(exp_key, rcon(ke_round_o));
    end
    assign ke_round_key_i = exp_key;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, ncyc);
        end
    endtask

    // Consumer backpressure, changed just after each rising edge.
    initial begin
        rk_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rk_ready_i = 1'b1;
                1:       rk_ready_i = ((ncyc + 1) >= ready_release);
                default: rk_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare process, sampling on the falling edge.
    initial begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        prev_cnt   = 3'd7;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                checkOutput("rst_round", 128'(ke_round_o), 128'd0);
                checkOutput("rst_cnt", 128'(ke_cnt_o), 128'd7);
                checkOutput("rst_valid", 128'(rk_valid_o), 128'd0);
                checkOutput("rst_data", rk_data_o, 128'd0);
                checkOutput("rst_idx", 128'(rk_idx_o), 128'd0);
                checkOutput("rst_busy", 128'(busy_o), 128'd0);
                checkOutput("rst_done", 128'(done_o), 128'd0);
                exp_idx    = 0;
                cnt5_count = 0;
                cur_stall  = 0;
                max_stall  = 0;
                prev_valid = 1'b0;
                prev_cnt   = 3'd7;
                for (int r = 0; r < 11; r++) first_seen[r] = -1;
            end else begin
                checkOutput("done", 128'(done_o), 128'(exp_idx == 11));
                if (exp_idx == 11) checkOutput("busy_after_done", 128'(busy_o), 128'd0);
                if (ke_cnt_o <= 3'd5) begin
                    checkOutput("cnt_only_in_gen", 128'(busy_o), 128'd1);
                    if (ke_cnt_o == 3'd0) begin
                        checkOutput("gen_entry", 128'(prev_cnt >= 3'd6), 128'd1);
                        checkOutput("round_at_gen", 128'(ke_round_o), 128'(cnt5_count));
                    end else begin
                        checkOutput("cnt_step", 128'(prev_cnt), 128'(ke_cnt_o - 3'd1));
                    end
                    if (ke_cnt_o == 3'd5) cnt5_count++;
                end else if (!busy_o) begin
                    checkOutput("cnt_idle", 128'(ke_cnt_o), 128'd7);
                end
                if (busy_o && ke_cnt_o == 3'd6) cur_stall++;
                else cur_stall = 0;
                if (cur_stall > max_stall) max_stall = cur_stall;
                if (prev_valid && !prev_ready) begin
                    checkOutput("hold_valid", 128'(rk_valid_o), 128'd1);
                    checkOutput("hold_data", rk_data_o, prev_data);
                    checkOutput("hold_idx", 128'(rk_idx_o), 128'(prev_idx));
                end
                if (rk_valid_o && int'(rk_idx_o) <= 10 && first_seen[rk_idx_o] < 0)
                    first_seen[rk_idx_o] = ncyc;
                if (rk_valid_o && rk_ready_i) begin
                    if (exp_idx > 10) begin
                        checkOutput("extra_key", 128'(rk_idx_o), 128'd15);
                    end else begin
                        checkOutput("pop_idx", 128'(rk_idx_o), 128'(exp_idx));
                        checkOutput("pop_data", rk_data_o, sched[exp_idx]);
                        exp_idx++;
                    end
                end
                prev_valid = rk_valid_o;
                prev_ready = rk_ready_i;
                prev_data  = rk_data_o;
                prev_idx   = rk_idx_o;
                prev_cnt   = ke_cnt_o;
            end
        end
    end

    task automatic pulseStart();
        @(posedge clk);
        #1;
        start_i = 1'b1;
        t0 = ncyc + 1;
        ready_release = t0 + 40;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // One full schedule: reset with a key, start, optionally reset mid-run,
    // then wait for all eleven keys and check the end state.
    task automatic applyStimulus(input logic [127:0] key, input int mode,
                                 input bit pin_latency, input bit mid_reset);
        int n;
        @(posedge clk);
        #1;
        start_i       = 1'b0;
        key_i         = key;
        ready_mode    = mode;
        ready_release = 1 << 30;
        rst_n         = 1'b0;
        computeSchedule(key);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulseStart();
        if (mid_reset) begin
            n = 0;
            while (!(busy_o && ke_round_o == 4'd5) && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            checkOutput("reached_round5", 128'(ke_round_o), 128'd5);
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            pulseStart();
        end
        n = 0;
        while (exp_idx < 11 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("all_keys_delivered", 128'(exp_idx), 128'd11);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("done_after_drain", 128'(done_o), 128'd1);
        checkOutput("rounds_run", 128'(cnt5_count), 128'd10);
        if (pin_latency) begin
            checkOutput("lat_idx0", 128'(first_seen[0]), 128'(t0 + 1));
            checkOutput("lat_idx1", 128'(first_seen[1]), 128'(t0 + 8));
            checkOutput("lat_idx5", 128'(first_seen[5]), 128'(t0 + 36));
            checkOutput("lat_idx10", 128'(first_seen[10]), 128'(t0 + 71));
        end
        if (mode == 1) checkOutput("cap_stall_seen", 128'(max_stall >= 2), 128'd1);
    endtask

    initial begin
        start_i = 1'b0;
        key_i   = FIPS_KEY;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;

        computeSchedule(FIPS_KEY);
        checkOutput("model_rk0", sched[0], FIPS_KEY);
        checkOutput("model_rk1", sched[1], FIPS_RK1);
        checkOutput("model_rk10", sched[10], FIPS_RK10);

        applyStimulus(FIPS_KEY, 0, 1'b1, 1'b0);

        @(posedge clk);
        #1 start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no_push_after_done", 128'(exp_idx), 128'd11);
        checkOutput("cnt_after_done", 128'(ke_cnt_o), 128'd7);
        start_i = 1'b0;

        applyStimulus(FIPS_KEY, 1, 1'b0, 1'b0);
        applyStimulus(FIPS_KEY, 2, 1'b0, 1'b0);
        applyStimulus(FIPS_KEY, 2, 1'b0, 1'b1);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
